fifo_wr_arbiter: RTL and testbench

Write-side arbiter that shares the single write port of the asynchronous FIFO among `NREQ` producers in the `wclk` domain. It grants the port round-robin in bursts, drives the FIFO write increment and data, and stalls the granted producer whenever the FIFO reports full. It sits directly in front of the write-pointer/full-flag logic and the FIFO memory write port.

---
 rtl/fifo_wr_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 33 +++
 rtl/fifo_wr_arbiter.sv | 117 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arb_pkg.sv
// rtl/fifo_wr_arb_pkg.sv - shared types and sizing for the FIFO write-port arbiter
package fifo_wr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Burst counter must hold the value MAXBURST itself, not just MAXBURST-1.
  function automatic int bcnt_width(input int maxburst);
    return $clog2(maxburst + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin first-one finder starting at ptr
module rr_pick #(
  parameter int NREQ = 4,
  localparam int PW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic            any
);

  logic [2*NREQ-1:0] dbl;
  logic [2*NREQ-1:0] rot;
  logic [NREQ-1:0]   oh;
  logic              found;

  // Rotate requests so ptr lands at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    dbl   = {req, req} >> ptr;
    oh    = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (dbl[k] && !found) begin
        oh[k] = 1'b1;
        found = 1'b1;
      end
    end
    rot = {{NREQ{1'b0}}, oh} << ptr;
    gnt = rot[NREQ-1:0] | rot[2*NREQ-1:NREQ];
    any = |req;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for the async FIFO write port
module fifo_wr_arbiter
  import fifo_wr_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int DSIZE    = 8,
  parameter int MAXBURST = 4
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic [NREQ-1:0]       grant,
  output logic                  busy
);

  localparam int PW = $clog2(NREQ);
  localparam int BW = bcnt_width(MAXBURST);

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;

  logic [NREQ-1:0]  pick_gnt;
  logic             pick_any;
  logic [PW-1:0]    owner_idx;
  logic [DSIZE-1:0] owner_data;
  logic             owner_valid;
  logic             owner_last;
  logic [PW-1:0]    ptr_next;
  logic [BW-1:0]    bcnt_inc;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .any (pick_any)
  );

  always_comb begin
    owner_idx  = '0;
    owner_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        owner_idx  = PW'(i);
        owner_data = req_data[i*DSIZE +: DSIZE];
      end
    end
  end

  assign owner_valid = |(req_valid & grant_q);
  assign owner_last  = |(req_last & grant_q);
  assign ptr_next    = (owner_idx == PW'(NREQ - 1)) ? '0 : owner_idx + 1'b1;
  assign bcnt_inc    = bcnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    bcnt_d    = bcnt_q;
    winc      = 1'b0;
    req_ready = '0;
    wdata     = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_gnt;
          bcnt_d  = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        req_ready = grant_q & {NREQ{~wfull}};
        wdata     = owner_data;
        winc      = owner_valid & ~wfull;
        // wfull freezes everything, including the abandon check.
        if (winc) begin
          bcnt_d = bcnt_inc;
          if (owner_last || bcnt_inc == BW'(MAXBURST)) begin
            state_d  = IDLE;
            grant_d  = '0;
            rr_ptr_d = ptr_next;
          end
        end else if (!wfull) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = ptr_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      bcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      bcnt_q   <= bcnt_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int DSIZE = 8;

  logic                  wclk = 1'b0;
  logic                  wrst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic                  wfull;

  logic [NREQ-1:0]  req_ready, req_ready1;
  logic             winc, winc1;
  logic [DSIZE-1:0] wdata, wdata1;
  logic [NREQ-1:0]  grant, grant1;
  logic             busy, busy1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 wclk = ~wclk;

  fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .MAXBURST(4)) u_dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .wfull     (wfull),
    .winc      (winc),
    .wdata     (wdata),
    .grant     (grant),
    .busy      (busy)
  );

  fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .MAXBURST(1)) u_dut1 (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready1),
    .wfull     (wfull),
    .winc      (winc1),
    .wdata     (wdata1),
    .grant     (grant1),
    .busy      (busy1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic set_data(input int idx, input logic [DSIZE-1:0] val);
    req_data[idx*DSIZE +: DSIZE] = val;
  endtask

  initial begin
    wrst_n    = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    wfull     = 1'b0;
    repeat (2) @(posedge wclk);
    @(negedge wclk);
    check_eq("rst_grant", grant, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_winc", winc, 0);
    check_eq("rst_ready", req_ready, 0);
    check_eq("rst_wdata", wdata, 0);
    wrst_n = 1'b1;

    // Single requester, 3-word packet
    tick();
    req_valid = 4'b0010;
    set_data(1, 8'hA1);
    @(negedge wclk);
    check_eq("t1_idle_grant", grant, 0);
    check_eq("t1_idle_winc", winc, 0);
    tick();
    @(negedge wclk);
    check_eq("t1_grant", grant, 4'b0010);
    check_eq("t1_busy", busy, 1);
    check_eq("t1_ready", req_ready, 4'b0010);
    check_eq("t1_winc0", winc, 1);
    check_eq("t1_wdata0", wdata, 8'hA1);
    tick();
    set_data(1, 8'hA2);
    @(negedge wclk);
    check_eq("t1_winc1", winc, 1);
    check_eq("t1_wdata1", wdata, 8'hA2);
    tick();
    set_data(1, 8'hA3);
    req_last = 4'b0010;
    @(negedge wclk);
    check_eq("t1_winc2", winc, 1);
    check_eq("t1_wdata2", wdata, 8'hA3);
    tick();
    req_valid = '0;
    req_last  = '0;
    @(negedge wclk);
    check_eq("t1_end_grant", grant, 0);
    check_eq("t1_end_busy", busy, 0);
    check_eq("t1_end_winc", winc, 0);
    check_eq("t1_end_wdata", wdata, 0);

    // rr_ptr must now be 2: with 0,1,3 valid the search from 2 lands on 3
    tick();
    req_valid = 4'b1011;
    @(negedge wclk);
    check_eq("ptr_idle", grant, 0);
    tick();
    @(negedge wclk);
    check_eq("ptr_grant", grant, 4'b1000);
    tick();
    req_valid = '0;
    @(negedge wclk);
    check_eq("ptr_abandon_busy", busy, 1);
    check_eq("ptr_abandon_winc", winc, 0);
    tick();
    @(negedge wclk);
    check_eq("ptr_abandon_idle", grant, 0);

    // Round-robin fairness, pointer back at 0
    tick();
    req_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_data(i, 8'hB0 + 8'(i));
    for (int b = 0; b < 5; b++) begin
      @(negedge wclk);
      check_eq("rr_idle_grant", grant, 0);
      check_eq("rr_idle_winc", winc, 0);
      for (int w = 0; w < 4; w++) begin
        tick();
        @(negedge wclk);
        check_eq("rr_grant", grant, 32'(1) << (b % 4));
        check_eq("rr_winc", winc, 1);
        check_eq("rr_wdata", wdata, 8'hB0 + 8'(b % 4));
      end
      tick();
      if (b == 4) req_valid = '0;
    end

    // Full stall mid-burst (pointer now 1, only requester 0 valid)
    req_valid = 4'b0001;
    set_data(0, 8'hC1);
    @(negedge wclk);
    check_eq("full_idle", grant, 0);
    tick();
    @(negedge wclk);
    check_eq("full_w0", wdata, 8'hC1);
    check_eq("full_winc0", winc, 1);
    tick();
    set_data(0, 8'hC2);
    @(negedge wclk);
    check_eq("full_w1", wdata, 8'hC2);
    tick();
    set_data(0, 8'hC3);
    wfull = 1'b1;
    for (int s = 0; s < 5; s++) begin
      @(negedge wclk);
      check_eq("full_stall_winc", winc, 0);
      check_eq("full_stall_ready", req_ready, 0);
      check_eq("full_stall_grant", grant, 4'b0001);
      tick();
    end
    wfull = 1'b0;
    @(negedge wclk);
    check_eq("full_resume_winc", winc, 1);
    check_eq("full_resume_w2", wdata, 8'hC3);
    tick();
    set_data(0, 8'hC4);
    @(negedge wclk);
    check_eq("full_w3_winc", winc, 1);
    check_eq("full_w3", wdata, 8'hC4);
    tick();
    req_valid = '0;
    @(negedge wclk);
    check_eq("full_end_grant", grant, 0);
    check_eq("full_end_busy", busy, 0);

    // Abandon: owner 2 drops valid, requester 0 waits (pointer 1)
    tick();
    req_valid = 4'b0100;
    set_data(2, 8'hD1);
    @(negedge wclk);
    check_eq("ab_idle", grant, 0);
    tick();
    @(negedge wclk);
    check_eq("ab_grant", grant, 4'b0100);
    check_eq("ab_wdata", wdata, 8'hD1);
    tick();
    req_valid = 4'b0001;
    @(negedge wclk);
    check_eq("ab_drop_busy", busy, 1);
    check_eq("ab_drop_winc", winc, 0);
    check_eq("ab_drop_ready", req_ready, 4'b0100);
    tick();
    @(negedge wclk);
    check_eq("ab_idle_grant", grant, 0);
    check_eq("ab_idle_busy", busy, 0);
    tick();
    @(negedge wclk);
    check_eq("ab_next_grant", grant, 4'b0001);
    tick();
    req_valid = '0;
    tick();
    @(negedge wclk);
    check_eq("ab_final_idle", grant, 0);

    // Reset mid-burst after two transfers by requester 3
    tick();
    req_valid = 4'b1000;
    set_data(3, 8'hF1);
    tick();
    @(negedge wclk);
    check_eq("mr_grant", grant, 4'b1000);
    tick();
    tick();
    req_valid = 4'b1010;
    @(negedge wclk);
    check_eq("mr_pre_winc", winc, 1);
    #2;
    wrst_n = 1'b0;
    #1;
    check_eq("mr_rst_winc", winc, 0);
    check_eq("mr_rst_grant", grant, 0);
    check_eq("mr_rst_busy", busy, 0);
    check_eq("mr_rst_ready", req_ready, 0);
    @(posedge wclk);
    @(negedge wclk);
    check_eq("mr_hold_grant", grant, 0);
    wrst_n = 1'b1;
    tick();
    @(negedge wclk);
    check_eq("mr_after_grant", grant, 4'b0010);
    tick();
    req_valid = '0;

    // MAXBURST=1 instance, last on every word, two requesters
    @(negedge wclk);
    wrst_n = 1'b0;
    @(posedge wclk);
    @(negedge wclk);
    wrst_n = 1'b1;
    tick();
    req_valid = 4'b0011;
    req_last  = 4'b0011;
    set_data(0, 8'hE0);
    set_data(1, 8'hE1);
    for (int r = 0; r < 4; r++) begin
      @(negedge wclk);
      check_eq("mb1_idle", grant1, 0);
      tick();
      @(negedge wclk);
      check_eq("mb1_grant", grant1, (r % 2 == 0) ? 4'b0001 : 4'b0010);
      check_eq("mb1_winc", winc1, 1);
      check_eq("mb1_wdata", wdata1, (r % 2 == 0) ? 8'hE0 : 8'hE1);
      tick();
    end
    req_valid = '0;
    req_last  = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
